// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
//   NumDigits : digits on the display
//   DecMax    : largest decimal value that fits in four digits
//   AnOff     : anode pattern with every digit switched off (active-low)
//   load_st_e : load FSM state encoding
package seg_scan_driver_pkg;

  localparam int unsigned NumDigits = 4;
  localparam logic [15:0] DecMax    = 16'd9999;
  localparam logic [3:0]  AnOff     = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } load_st_e;

  // Active-low one-hot anode select for digit slot idx.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : load bin_i and begin a 16-iteration conversion
//   bin_i        : binary operand (caller keeps it <= 9999)
//   done_o       : high during the cycle whose closing edge performs the last iteration
//   bcd_o        : BCD result, valid from the edge after done_o until the next start
module bin16_to_bcd_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [15:0] adj;

  always_comb begin
    // Add 3 to each nibble >= 5 before the shift.
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == 4'd15);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Front end for a BCD-to-7-segment decoder driving a 4-digit common-anode display.
// Accepts a 16-bit value over valid/ready, shows it as decimal (clamped to 9999) or as
// four raw hex nibbles, and time-multiplexes the digits onto one decoder.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   data_in_i      : value to display
//   data_valid_i   : data_in_i / hex_mode_i qualified
//   data_ready_o   : block can accept (load FSM idle)
//   hex_mode_i     : sampled at transfer; 1 = hex nibbles, 0 = decimal
//   blank_lz_i     : live; blank leading zero digits (digit 0 never blanked)
//   disp_en_i      : live; 0 = all anodes off and decoder disabled
//   bcd_o, en_o    : digit code and enable to the decoder
//   an_o           : active-low anodes, an_o[0] = least-significant digit
//   ovf_o          : last decimal load exceeded 9999 and was clamped
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] data_in_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic        hex_mode_i,
  input  logic        blank_lz_i,
  input  logic        disp_en_i,
  output logic [3:0]  bcd_o,
  output logic        en_o,
  output logic [3:0]  an_o,
  output logic        ovf_o
);

  load_st_e state_q, state_d;

  logic [4*NumDigits-1:0] digit_q, digit_d;
  logic                   ovf_q, ovf_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             an_q, an_d;
  logic [3:0]             bcd_q, bcd_d;
  logic                   en_q, en_d;

  logic                   xfer;
  logic                   conv_start;
  logic                   conv_done;
  logic                   dec_commit;
  logic [15:0]            conv_bcd;
  logic [15:0]            operand;
  logic [NumDigits-1:0]   blank;
  logic                   div_wrap;

  // ---------------- Load FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer && !hex_mode_i) state_d = StShift;
      StShift: if (conv_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_ready_o = (state_q == StIdle);
    dec_commit   = (state_q == StDone);
  end

  assign xfer       = data_valid_i && data_ready_o;
  assign conv_start = xfer && !hex_mode_i;
  assign operand    = (data_in_i > DecMax) ? DecMax : data_in_i;

  bin16_to_bcd_seq u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (conv_start),
    .bin_i   (operand),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // ---------------- Digit and overflow registers ----------------
  always_comb begin
    digit_d = digit_q;
    ovf_d   = ovf_q;
    if (xfer) begin
      if (hex_mode_i) begin
        digit_d = data_in_i;
        ovf_d   = 1'b0;
      end else begin
        ovf_d = (data_in_i > DecMax);
      end
    end
    if (dec_commit) begin
      digit_d = conv_bcd;
    end
  end

  // ---------------- Scan ----------------
  // A digit is blank when it and every more-significant digit are zero.
  always_comb begin
    blank[3] = blank_lz_i && (digit_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digit_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digit_q[7:4] == 4'd0);
    blank[0] = 1'b0;
  end

  assign div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));

  always_comb begin
    div_d = div_wrap ? '0 : div_q + 1'b1;
    idx_d = div_wrap ? idx_q + 2'd1 : idx_q;
    // Outputs are registered from the current idx, so they trail idx by one cycle.
    an_d  = disp_en_i ? anode_sel(idx_q) : AnOff;
    bcd_d = digit_q[{idx_q, 2'b00} +: 4];
    en_d  = disp_en_i && !blank[idx_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= AnOff;
      bcd_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
    end
  end

  assign an_o  = an_q;
  assign bcd_o = bcd_q;
  assign en_o  = en_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4. The driver predicts every accepted load
// and queues its effect with the edge at which it lands; the monitor applies queued
// effects by edge number and checks the scan outputs each cycle.
module tb_seg_scan_driver;

  localparam int unsigned RefDiv = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_in_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic        hex_mode_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic        disp_en_i = 1'b1;
  logic [3:0]  bcd_o;
  logic        en_o;
  logic [3:0]  an_o;
  logic        ovf_o;

  seg_scan_driver #(
    .REFRESH_DIV (RefDiv),
    .DIV_W       (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_in_i    (data_in_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .hex_mode_i   (hex_mode_i),
    .blank_lz_i   (blank_lz_i),
    .disp_en_i    (disp_en_i),
    .bcd_o        (bcd_o),
    .en_o         (en_o),
    .an_o         (an_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned e;
    logic [15:0] v;
  } ev_t;

  ev_t dig_q[$];
  ev_t ovf_q[$];
  ev_t busy_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v packed one per nibble, least significant digit in [3:0].
  function automatic logic [15:0] to_dec(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (16'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // ---------------- Driver ----------------
  int unsigned drv_e    = 0;
  int unsigned busy_end = 0;

  task automatic step(input logic v, input logic [15:0] d, input logic h, input logic r);
    int unsigned e;
    int unsigned val;
    ev_t ev;
    e            = drv_e + 1;
    rst_i        = r;
    data_valid_i = v;
    data_in_i    = d;
    hex_mode_i   = h;
    if (r) begin
      busy_end = 0;
    end else if (v && e >= busy_end) begin
      if (h) begin
        ev.e = e; ev.v = d;     dig_q.push_back(ev);
        ev.e = e; ev.v = 16'd0; ovf_q.push_back(ev);
      end else begin
        val  = (int'(d) > 9999) ? 9999 : int'(d);
        ev.e = e + 17; ev.v = to_dec(val);                  dig_q.push_back(ev);
        ev.e = e;      ev.v = {15'd0, (int'(d) > 9999)};    ovf_q.push_back(ev);
        ev.e = e;      ev.v = 16'd0;                        busy_q.push_back(ev);
        busy_end = e + 18;
      end
    end
    @(posedge clk_i);
    #1;
    drv_e++;
    data_valid_i = 1'b0;
    rst_i        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // ---------------- Monitor ----------------
  initial begin
    int unsigned e;
    int unsigned r_e;
    int unsigned k;
    int unsigned slot;
    int unsigned lo;
    int unsigned hi;
    bit          have_reset;
    logic [15:0] cur_dig;
    logic        cur_ovf;
    logic        rst_s, den_s, lz_s;
    logic [3:0]  x_an, x_bcd;
    logic        x_en, x_rdy;
    e = 0; r_e = 0; lo = 0; hi = 0; have_reset = 0;
    cur_dig = '0; cur_ovf = 1'b0;
    x_an = 4'hF; x_bcd = 4'h0; x_en = 1'b0; x_rdy = 1'b1;
    forever begin
      @(posedge clk_i);
      e++;
      rst_s = rst_i;
      den_s = disp_en_i;
      lz_s  = blank_lz_i;
      if (rst_s) begin
        have_reset = 1;
        r_e        = e;
        dig_q.delete();
        ovf_q.delete();
        busy_q.delete();
        cur_dig = '0;
        cur_ovf = 1'b0;
        lo = 0; hi = 0;
        x_an = 4'hF; x_bcd = 4'h0; x_en = 1'b0;
      end else if (have_reset) begin
        k     = e - r_e;
        slot  = ((k - 1) / RefDiv) % 4;
        x_bcd = 4'((cur_dig >> (4 * slot)) & 16'hF);
        x_an  = den_s ? ~(4'(1) << slot) : 4'hF;
        x_en  = den_s && !(lz_s && slot > 0 && (cur_dig >> (4 * slot)) == 16'd0);
        while (dig_q.size() > 0 && dig_q[0].e <= e) cur_dig = dig_q.pop_front().v;
        while (ovf_q.size() > 0 && ovf_q[0].e <= e) cur_ovf = ovf_q.pop_front().v[0];
        while (busy_q.size() > 0 && busy_q[0].e <= e) begin
          lo = busy_q[0].e;
          hi = busy_q[0].e + 17;
          void'(busy_q.pop_front());
        end
      end
      x_rdy = !(e >= lo && e < hi && !rst_s);
      @(negedge clk_i);
      if (have_reset) begin
        check("an", {12'd0, an_o}, {12'd0, x_an});
        check("bcd", {12'd0, bcd_o}, {12'd0, x_bcd});
        check("en", {15'd0, en_o}, {15'd0, x_en});
        check("data_ready", {15'd0, data_ready_o}, {15'd0, x_rdy});
        check("ovf", {15'd0, ovf_o}, {15'd0, cur_ovf});
      end
    end
  end

  // ---------------- Stimulus ----------------
  initial begin
    // Reset held with a valid hex load pending: nothing must be loaded.
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    idle(2);

    step(1'b1, 16'hBEEF, 1'b1, 1'b0);      // hex load
    idle(20);
    step(1'b1, 16'd1234, 1'b0, 1'b0);      // decimal load
    idle(36);
    step(1'b1, 16'd12345, 1'b0, 1'b0);     // clamp
    idle(24);
    step(1'b1, 16'h0000, 1'b1, 1'b0);      // hex clears ovf
    idle(18);

    blank_lz_i = 1'b1;
    step(1'b1, 16'd7, 1'b0, 1'b0);
    idle(36);
    blank_lz_i = 1'b0;
    idle(16);

    step(1'b1, 16'd42, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 16'd5555, 1'b0, 1'b0);      // ignored while converting
    idle(30);
    step(1'b1, 16'd9876, 1'b0, 1'b0);
    idle(7);
    step(1'b0, 16'h0, 1'b0, 1'b1);         // reset mid-conversion
    idle(20);

    step(1'b1, 16'h0A05, 1'b1, 1'b0);
    disp_en_i = 1'b0;
    idle(10);
    disp_en_i = 1'b1;
    idle(16);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) blank_lz_i = ~blank_lz_i;
      disp_en_i = ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
